// File: rtl/lpc_window_sequencer_pkg.sv
// Shared definitions for the LPC analysis-window read sequencer.
// Holds the sequencer state encoding and the window/sample geometry.
package lpc_window_sequencer_pkg;

   localparam int LPC_WIN_LEN  = 240;
   localparam int LPC_SAMPLE_W = 16;
   localparam int LPC_CNT_W    = 8;
   localparam int LPC_MAX_PEND = 2;

   typedef enum logic [1:0] {
      SEQ_IDLE    = 2'd0,
      SEQ_ISSUE   = 2'd1,
      SEQ_DRAIN   = 2'd2,
      SEQ_WAIT_AC = 2'd3
   } seq_state_t;

endpackage

// File: rtl/lpc_window_sequencer_skid_buf.sv
// Two-entry valid/ready skid FIFO carrying {index, sample} to the window stream.
// Head entry is presented straight from storage, so data holds until popped.
module lpc_window_sequencer_skid_buf #(
   parameter int W = 24
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   level
);

   logic [W-1:0] mem_r [0:1];
   logic         wr_ptr_r;
   logic         rd_ptr_r;
   logic [1:0]   level_r;
   logic         push_s;
   logic         pop_s;

   assign in_ready  = (level_r != 2'd2);
   assign out_valid = (level_r != 2'd0);
   assign out_data  = mem_r[rd_ptr_r];
   assign level     = level_r;
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;

   // Occupancy and pointer bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         level_r  <= 2'd0;
      end else begin
         if (push_s) wr_ptr_r <= ~wr_ptr_r;
         if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
         level_r <= level_r + {1'b0, push_s} - {1'b0, pop_s};
      end
   end

   // Payload storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clock) begin
      if (push_s) mem_r[wr_ptr_r] <= in_data;
   end

endmodule

// File: rtl/lpc_window_sequencer.sv
// Read-side sequencer for the LPC sample buffer: queues frame_done events, sweeps
// one analysis window per event to the autocorrelation stream, then waits for ac_done.
module lpc_window_sequencer
   import lpc_window_sequencer_pkg::*;
#(
   parameter int WIN_LEN  = LPC_WIN_LEN,
   parameter int CNT_W    = LPC_CNT_W,
   parameter int DATA_W   = LPC_SAMPLE_W,
   parameter int MAX_PEND = LPC_MAX_PEND
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              frame_done,
   output logic [CNT_W-1:0]  rd_count,
   input  logic [DATA_W-1:0] rd_sample,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [DATA_W-1:0] win_sample,
   output logic [CNT_W-1:0]  win_index,
   output logic              win_start,
   output logic              win_last,
   input  logic              ac_done,
   output logic              busy,
   output logic [1:0]        pend_cnt,
   output logic              overrun
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       PEND_MAX = 2'(MAX_PEND);

   seq_state_t          state_r, state_s;
   logic [CNT_W-1:0]    rd_count_r;
   logic                issue_valid_r;
   logic [CNT_W-1:0]    issue_idx_r;
   logic                win_start_r;
   logic [1:0]          pend_cnt_r;
   logic                overrun_r;
   logic                start_s, issue_s, can_issue_s, pop_s, pop_last_s;
   logic                skid_in_ready_s, skid_out_valid_s;
   logic [1:0]          skid_level_s;
   logic [CNT_W+DATA_W-1:0] skid_out_s;
   logic [CNT_W-1:0]    skid_idx_s;

   lpc_window_sequencer_skid_buf #(.W(CNT_W + DATA_W)) u_skid (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (issue_valid_r),
      .in_ready  (skid_in_ready_s),
      .in_data   ({issue_idx_r, rd_sample}),
      .out_valid (skid_out_valid_s),
      .out_ready (win_ready),
      .out_data  (skid_out_s),
      .level     (skid_level_s)
   );

   assign skid_idx_s = skid_out_s[CNT_W+DATA_W-1:DATA_W];
   assign pop_s      = skid_out_valid_s && win_ready;
   assign pop_last_s = pop_s && (skid_idx_s == LAST_IDX);

   // A read issued now lands in the skid next cycle, so count the one in flight.
   always_comb begin
      can_issue_s = 1'b0;
      if (!skid_in_ready_s) begin
         can_issue_s = pop_s;
      end else if (skid_level_s == 2'd1) begin
         can_issue_s = !(issue_valid_r && !pop_s);
      end else begin
         can_issue_s = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state_r <= SEQ_IDLE;
      else       state_r <= state_s;
   end

   always_comb begin
      state_s = state_r;
      start_s = 1'b0;
      issue_s = 1'b0;
      case (state_r)
         SEQ_IDLE: begin
            if (pend_cnt_r != 2'd0) begin
               start_s = 1'b1;
               state_s = SEQ_ISSUE;
            end else begin
               state_s = SEQ_IDLE;
            end
         end
         SEQ_ISSUE: begin
            if (can_issue_s) begin
               issue_s = 1'b1;
               if (rd_count_r == LAST_IDX) state_s = SEQ_DRAIN;
               else                        state_s = SEQ_ISSUE;
            end else begin
               state_s = SEQ_ISSUE;
            end
         end
         SEQ_DRAIN: begin
            if (pop_last_s) state_s = SEQ_WAIT_AC;
            else            state_s = SEQ_DRAIN;
         end
         SEQ_WAIT_AC: begin
            if (ac_done) state_s = SEQ_IDLE;
            else         state_s = SEQ_WAIT_AC;
         end
         default: state_s = SEQ_IDLE;
      endcase
   end

   // Issue counter and the one-cycle tag pipe matching the buffer read latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_count_r    <= {CNT_W{1'b0}};
         issue_valid_r <= 1'b0;
         issue_idx_r   <= {CNT_W{1'b0}};
         win_start_r   <= 1'b0;
      end else begin
         win_start_r   <= start_s;
         issue_valid_r <= issue_s;
         issue_idx_r   <= rd_count_r;
         if (issue_s) begin
            if (rd_count_r == LAST_IDX) rd_count_r <= {CNT_W{1'b0}};
            else                        rd_count_r <= rd_count_r + IDX_ONE;
         end
      end
   end

   // Pending frame queue; a coincident arrival and start cancel out.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_cnt_r <= 2'd0;
         overrun_r  <= 1'b0;
      end else if (frame_done && !start_s) begin
         if (pend_cnt_r == PEND_MAX) overrun_r  <= 1'b1;
         else                        pend_cnt_r <= pend_cnt_r + 2'd1;
      end else if (start_s && !frame_done) begin
         pend_cnt_r <= pend_cnt_r - 2'd1;
      end
   end

   assign rd_count   = rd_count_r;
   assign win_valid  = skid_out_valid_s;
   assign win_index  = skid_out_valid_s ? skid_idx_s : {CNT_W{1'b0}};
   assign win_sample = skid_out_valid_s ? skid_out_s[DATA_W-1:0] : {DATA_W{1'b0}};
   assign win_last   = skid_out_valid_s && (skid_idx_s == LAST_IDX);
   assign win_start  = win_start_r;
   assign busy       = (state_r != SEQ_IDLE);
   assign pend_cnt   = pend_cnt_r;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_lpc_window_sequencer.sv
// Bench for lpc_window_sequencer: directed vector table, hand-written corner sequences
// and randomized consumer back-pressure against a transaction-level window model.
module tb_lpc_window_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_done = 1'b0;
   logic [7:0]  rd_count;
   logic [15:0] rd_sample = 16'd0;
   logic        win_valid;
   logic        win_ready = 1'b0;
   logic [15:0] win_sample;
   logic [7:0]  win_index;
   logic        win_start;
   logic        win_last;
   logic        ac_done = 1'b0;
   logic        busy;
   logic [1:0]  pend_cnt;
   logic        overrun;

   lpc_window_sequencer dut (
      .clock(clock), .reset(reset), .frame_done(frame_done), .rd_count(rd_count),
      .rd_sample(rd_sample), .win_valid(win_valid), .win_ready(win_ready),
      .win_sample(win_sample), .win_index(win_index), .win_start(win_start),
      .win_last(win_last), .ac_done(ac_done), .busy(busy), .pend_cnt(pend_cnt),
      .overrun(overrun)
   );

   always #5 clock = ~clock;

   logic [15:0] buf_mem [0:255];
   always @(posedge clock) rd_sample <= buf_mem[rd_count];

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;

   // Window model: pending frames, phase 0 idle / 1 sweeping / 2 awaiting ac_done.
   int pend_m = 0, phase_m = 0, exp_idx = 0, cyc = 0, start_cyc = 0, last_cyc = 0;
   bit ovr_m = 1'b0, start_exp = 1'b0, hold_v = 1'b0;
   logic [7:0]  hold_idx;
   logic [15:0] hold_smp;

   typedef struct {
      logic       rst, fd, ac, rdy;
      logic       busy;
      logic [1:0] pend;
      logic       ovr, st, vld;
      logic [7:0] rd;
   } vec_t;
   vec_t vec [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic tick();
      logic acc;
      bit   dec;
      #1;
      acc = win_valid && win_ready;
      if (checking) begin
         chk("pend_cnt", 32'(pend_cnt), 32'(pend_m));
         chk("overrun", 32'(overrun), 32'(ovr_m));
         chk("busy", 32'(busy), 32'(phase_m != 0));
         chk("win_start", 32'(win_start), 32'(start_exp));
         chk("rd_count_max", 32'(rd_count <= 8'd239), 32'd1);
         if (phase_m != 1) chk("rd_count_rest", 32'(rd_count), 32'd0);
         if (hold_v) begin
            chk("hold_valid", 32'(win_valid), 32'd1);
            chk("hold_index", 32'(win_index), 32'(hold_idx));
            chk("hold_sample", 32'(win_sample), 32'(hold_smp));
         end
         if (win_valid) begin
            chk("valid_in_sweep", 32'(phase_m == 1), 32'd1);
            chk("win_last", 32'(win_last), 32'(win_index == 8'd239));
         end else begin
            chk("win_last_idle", 32'(win_last), 32'd0);
         end
         if (acc) begin
            chk("index", 32'(win_index), 32'(exp_idx));
            chk("sample", 32'(win_sample), 32'(buf_mem[exp_idx]));
         end
      end
      if (reset) begin
         pend_m = 0; ovr_m = 1'b0; phase_m = 0; exp_idx = 0; start_exp = 1'b0; hold_v = 1'b0;
      end else begin
         dec = (phase_m == 0) && (pend_m > 0);
         start_exp = dec;
         if (frame_done && !dec) begin
            if (pend_m == 2) ovr_m = 1'b1;
            else             pend_m++;
         end else if (dec && !frame_done) begin
            pend_m--;
         end
         if (phase_m == 0 && dec) begin
            phase_m = 1; start_cyc = cyc + 1;
         end else if (phase_m == 1 && acc === 1'b1) begin
            exp_idx++;
            if (exp_idx == 240) begin phase_m = 2; exp_idx = 0; last_cyc = cyc; end
         end else if (phase_m == 2 && ac_done) begin
            phase_m = 0;
         end
         hold_v   = (win_valid === 1'b1) && !win_ready;
         hold_idx = win_index;
         hold_smp = win_sample;
      end
      cyc++;
      @(negedge clock);
      frame_done = 1'b0;
      ac_done    = 1'b0;
   endtask

   task automatic run_sweep(input bit rnd, input int ac_at);
      int n = 0;
      while (phase_m != 2 && n < 3000) begin
         win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (n == ac_at) ac_done = 1'b1;
         tick();
         n++;
      end
      chk("sweep_complete", 32'(phase_m == 2), 32'd1);
   endtask

   task automatic finish_window(input int gap);
      win_ready = 1'b1;
      repeat (gap) tick();
      ac_done = 1'b1;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base, step, n;
      bit found;
      base = int'($urandom_range(0, 65535));
      step = int'($urandom_range(1, 97));
      for (int i = 0; i < 256; i++) buf_mem[i] = 16'(base + i * step);

      //          rst   fd    ac    rdy  | busy  pend  ovr   st    vld   rd
      vec[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
      vec[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0};
      vec[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0};
      vec[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1};
      vec[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd2};
      vec[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd3};
      vec[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd4};

      @(negedge clock);
      repeat (2) tick();
      checking = 1'b1;

      for (int i = 0; i < 7; i++) begin
         reset = vec[i].rst; frame_done = vec[i].fd; ac_done = vec[i].ac; win_ready = vec[i].rdy;
         tick();
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vec[i].busy));
         chk($sformatf("vec%0d_pend", i), 32'(pend_cnt), 32'(vec[i].pend));
         chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vec[i].ovr));
         chk($sformatf("vec%0d_start", i), 32'(win_start), 32'(vec[i].st));
         chk($sformatf("vec%0d_valid", i), 32'(win_valid), 32'(vec[i].vld));
         chk($sformatf("vec%0d_rd_count", i), 32'(rd_count), 32'(vec[i].rd));
      end

      // First window at full rate, then the two queued windows run.
      run_sweep(1'b0, -1);
      chk("latency_w1", 32'(last_cyc - start_cyc), 32'd241);
      finish_window(10);
      run_sweep(1'b1, 50);
      finish_window(5);

      // Third window: reset while index 100 is stalled on the stream.
      n = 0; found = 1'b0;
      while (!found && n < 2000) begin
         if (win_valid === 1'b1 && win_index == 8'd100) begin
            found = 1'b1;
         end else begin
            win_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
      end
      chk("reach_idx100", 32'(found), 32'd1);
      win_ready = 1'b0; reset = 1'b1;
      tick();
      chk("rst_valid", 32'(win_valid), 32'd0);
      chk("rst_rd_count", 32'(rd_count), 32'd0);
      chk("rst_index", 32'(win_index), 32'd0);
      chk("rst_sample", 32'(win_sample), 32'd0);
      chk("rst_outs", 32'({win_start, win_last, busy, pend_cnt, overrun}), 32'd0);
      reset = 1'b0;
      repeat (5) tick();
      chk("post_rst_idle", 32'({win_valid, busy}), 32'd0);

      // frame_done coincident with the idle-to-issue step while one frame is pending.
      win_ready = 1'b1;
      frame_done = 1'b1; tick();
      frame_done = 1'b1; tick();
      chk("coinc_pend", 32'(pend_cnt), 32'd1);
      chk("coinc_overrun", 32'(overrun), 32'd0);
      chk("coinc_start", 32'(win_start), 32'd1);
      run_sweep(1'b0, -1);
      chk("latency_w4", 32'(last_cyc - start_cyc), 32'd241);
      finish_window(3);
      run_sweep(1'b1, 20);
      finish_window(2);
      repeat (3) tick();
      chk("final_idle", 32'({busy, pend_cnt}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
